serv_wb_arbiter: RTL and testbench

Two-master Wishbone-classic arbiter that shares one memory/peripheral port between the SERV core's instruction bus and data bus. It sits between `serv_rf_top` and the single-ported SoC memory. Fairness is round-robin, with outputs registered toward the shared port and single-cycle ack pulses returned to the granted master. An optional watchdog terminates hung slave transactions.

---
 rtl/serv_wb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_serv_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_wb_arbiter.sv
// Round-robin Wishbone-classic arbiter sharing one slave port between SERV's ibus and dbus.
// Optional slave watchdog enabled by defining SERV_WB_ARBITER_TIMEOUT_EN.
module serv_wb_arbiter #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    if (TIMEOUT_W < 1) begin : g_bad_timeout_w
        $error("TIMEOUT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          last_grant;
    logic          last_grant_nxt;
    logic          in_gnt;
    logic          to_hit;
    logic [DW-1:0] done_rdt;

    logic [DW-1:0] wb_adr_nxt;
    logic [DW-1:0] wb_dat_nxt;
    logic [SW-1:0] wb_sel_nxt;
    logic          wb_we_nxt;
    logic          wb_cyc_nxt;
    logic          ibus_ack_nxt;
    logic [DW-1:0] ibus_rdt_nxt;
    logic          dbus_ack_nxt;
    logic [DW-1:0] dbus_rdt_nxt;

    assign in_gnt   = (state == GNT_I) || (state == GNT_D);
    // A watchdog completion returns all-ones; a real ack always wins.
    assign done_rdt = i_wb_ack ? i_wb_rdt : {DW{1'b1}};

`ifdef SERV_WB_ARBITER_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_ALL = '1;

    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + TIMEOUT_W'(1);
    // Fires on the edge that ends the (2^W-1)th cycle of a grant.
    assign to_hit  = (cnt_inc == CNT_ALL);

    always_ff @(posedge clk) begin
        if (i_rst || !in_gnt) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= in_gnt && to_hit && !i_wb_ack;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_ibus_cyc && (!i_dbus_cyc || last_grant)) begin
                    state_nxt = GNT_I;
                end else if (i_dbus_cyc) begin
                    state_nxt = GNT_D;
                end
            end
            GNT_I: begin
                if (i_wb_ack || to_hit) begin
                    state_nxt = DONE;
                end else if (!i_ibus_cyc) begin
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (i_wb_ack || to_hit) begin
                    state_nxt = DONE;
                end else if (!i_dbus_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output next-values: latch request on grant, pulse ack on completion
    always_comb begin
        wb_adr_nxt     = o_wb_adr;
        wb_dat_nxt     = o_wb_dat;
        wb_sel_nxt     = o_wb_sel;
        wb_we_nxt      = o_wb_we;
        wb_cyc_nxt     = o_wb_cyc;
        ibus_ack_nxt   = 1'b0;
        ibus_rdt_nxt   = '0;
        dbus_ack_nxt   = 1'b0;
        dbus_rdt_nxt   = '0;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (state_nxt == GNT_I) begin
                    wb_adr_nxt     = i_ibus_adr;
                    wb_dat_nxt     = '0;
                    wb_sel_nxt     = {SW{1'b1}};
                    wb_we_nxt      = 1'b0;
                    wb_cyc_nxt     = 1'b1;
                    last_grant_nxt = 1'b0;
                end else if (state_nxt == GNT_D) begin
                    wb_adr_nxt     = i_dbus_adr;
                    wb_dat_nxt     = i_dbus_dat;
                    wb_sel_nxt     = i_dbus_sel;
                    wb_we_nxt      = i_dbus_we;
                    wb_cyc_nxt     = 1'b1;
                    last_grant_nxt = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (state_nxt == DONE) begin
                    wb_cyc_nxt = 1'b0;
                    if (state == GNT_I) begin
                        ibus_ack_nxt = 1'b1;
                        ibus_rdt_nxt = done_rdt;
                    end else begin
                        dbus_ack_nxt = 1'b1;
                        dbus_rdt_nxt = done_rdt;
                    end
                end else if (state_nxt == IDLE) begin
                    wb_cyc_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and arbitration-history registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_wb_adr   <= '0;
            o_wb_dat   <= '0;
            o_wb_sel   <= '0;
            o_wb_we    <= 1'b0;
            o_wb_cyc   <= 1'b0;
            o_ibus_ack <= 1'b0;
            o_ibus_rdt <= '0;
            o_dbus_ack <= 1'b0;
            o_dbus_rdt <= '0;
            last_grant <= 1'b1;
        end else begin
            o_wb_adr   <= wb_adr_nxt;
            o_wb_dat   <= wb_dat_nxt;
            o_wb_sel   <= wb_sel_nxt;
            o_wb_we    <= wb_we_nxt;
            o_wb_cyc   <= wb_cyc_nxt;
            o_ibus_ack <= ibus_ack_nxt;
            o_ibus_rdt <= ibus_rdt_nxt;
            o_dbus_ack <= dbus_ack_nxt;
            o_dbus_rdt <= dbus_rdt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Bench for serv_wb_arbiter: directed scenarios plus random masters/slave checked
// every cycle against a transaction-level reference model.
module tb_serv_wb_arbiter;

    localparam int unsigned TW = 4;
`ifdef SERV_WB_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYCLES = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_ibus_adr = '0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr = '0;
    logic [31:0] i_dbus_dat = '0;
    logic [3:0]  i_dbus_sel = '0;
    logic        i_dbus_we = 1'b0;
    logic        i_dbus_cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt = '0;
    logic        i_wb_ack = 1'b0;
    logic        o_timeout;

    always #5 clk = ~clk;

    serv_wb_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .o_timeout  (o_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: owner 0 = none, 1 = ibus, 2 = dbus
    int          owner    = 0;
    bit          in_done  = 1'b0;
    bit          prefer_d = 1'b0;
    int          elapsed  = 0;
    logic [31:0] e_adr = '0, e_dat = '0, e_irdt = '0, e_drdt = '0;
    logic [3:0]  e_sel = '0;
    logic        e_we = 1'b0, e_cyc = 1'b0, e_iack = 1'b0, e_dack = 1'b0, e_to = 1'b0;

    function automatic void finish_xfer(input logic [31:0] rdt, input logic timed_out);
        e_cyc = 1'b0;
        e_to  = timed_out;
        if (owner == 1) begin e_iack = 1'b1; e_irdt = rdt; end
        else            begin e_dack = 1'b1; e_drdt = rdt; end
        owner   = 0;
        in_done = 1'b1;
    endfunction

    // Predict outputs after the coming edge from the inputs presented to it.
    function automatic void model_advance();
        e_iack = 1'b0; e_dack = 1'b0; e_irdt = '0; e_drdt = '0; e_to = 1'b0;
        if (i_rst) begin
            owner = 0; in_done = 1'b0; prefer_d = 1'b0;
            e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0;
        end else if (in_done) begin
            in_done = 1'b0;
        end else if (owner == 0) begin
            if (i_ibus_cyc && (!i_dbus_cyc || !prefer_d)) begin
                owner = 1; prefer_d = 1'b1; elapsed = 0;
                e_adr = i_ibus_adr; e_dat = '0; e_sel = 4'hF; e_we = 1'b0; e_cyc = 1'b1;
            end else if (i_dbus_cyc) begin
                owner = 2; prefer_d = 1'b0; elapsed = 0;
                e_adr = i_dbus_adr; e_dat = i_dbus_dat; e_sel = i_dbus_sel;
                e_we = i_dbus_we; e_cyc = 1'b1;
            end
        end else begin
            elapsed++;
            if (i_wb_ack) finish_xfer(i_wb_rdt, 1'b0);
            else if (TO_EN && elapsed == TO_CYCLES) finish_xfer(32'hFFFF_FFFF, 1'b1);
            else if ((owner == 1 && !i_ibus_cyc) || (owner == 2 && !i_dbus_cyc)) begin
                e_cyc = 1'b0;
                owner = 0;
            end
        end
    endfunction

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        check("wb_adr",   o_wb_adr,        e_adr);
        check("wb_dat",   o_wb_dat,        e_dat);
        check("wb_sel",   32'(o_wb_sel),   32'(e_sel));
        check("wb_we",    32'(o_wb_we),    32'(e_we));
        check("wb_cyc",   32'(o_wb_cyc),   32'(e_cyc));
        check("ibus_ack", 32'(o_ibus_ack), 32'(e_iack));
        check("ibus_rdt", o_ibus_rdt,      e_irdt);
        check("dbus_ack", 32'(o_dbus_ack), 32'(e_dack));
        check("dbus_rdt", o_dbus_rdt,      e_drdt);
        check("timeout",  32'(o_timeout),  32'(e_to));
    endtask

    task automatic reset_dut();
        i_rst = 1'b1; i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0; i_wb_ack = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        int n_i, n_d, nexp, idx, n_to;
        logic prev;

        // Reset state, then single ibus fetch with a two-cycle slave
        reset_dut();
        check("rst_cyc", 32'(o_wb_cyc), 32'd0);
        i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1; i_wb_rdt = 32'hDEAD_BEEF;
        step();
        check("t1_cyc_rise", 32'(o_wb_cyc), 32'd1);
        check("t1_adr", o_wb_adr, 32'h100);
        check("t1_sel", 32'(o_wb_sel), 32'hF);
        step();
        i_wb_ack = 1'b1;
        step();
        check("t1_ack", 32'(o_ibus_ack), 32'd1);
        check("t1_rdt", o_ibus_rdt, 32'hDEAD_BEEF);
        i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
        step();
        check("t1_ack_pulse", 32'(o_ibus_ack), 32'd0);

        // dbus write
        i_dbus_adr = 32'h2000; i_dbus_dat = 32'h1234_5678; i_dbus_sel = 4'b0011;
        i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
        step();
        check("t2_dat", o_wb_dat, 32'h1234_5678);
        check("t2_sel", 32'(o_wb_sel), 32'h3);
        check("t2_we", 32'(o_wb_we), 32'd1);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h0BAD_F00D;
        step();
        check("t2_ack", 32'(o_dbus_ack), 32'd1);
        check("t2_no_iack", 32'(o_ibus_ack), 32'd0);
        i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
        step();
        check("t2_ack_pulse", 32'(o_dbus_ack), 32'd0);

        // Continuous collision: grants alternate starting with ibus
        reset_dut();
        i_ibus_adr = 32'h1000; i_dbus_adr = 32'h2000; i_dbus_we = 1'b0; i_dbus_sel = 4'hF;
        i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
        n_i = 0; n_d = 0; nexp = 0; prev = 1'b0;
        repeat (24) begin
            step();
            if (o_wb_cyc && !prev) begin
                check("alt_grant", 32'(o_wb_adr == 32'h2000), 32'(nexp % 2));
                nexp++;
            end
            prev = o_wb_cyc;
            n_i += int'(o_ibus_ack);
            n_d += int'(o_dbus_ack);
            i_ibus_cyc = !o_ibus_ack;
            i_dbus_cyc = !o_dbus_ack;
            i_wb_ack = o_wb_cyc;
            i_wb_rdt = $urandom;
        end
        check("alt_iacks", 32'(n_i), 32'd4);
        check("alt_dacks", 32'(n_d), 32'd4);

        // Reset during a dbus grant, late ack ignored, next collision goes to ibus
        reset_dut();
        i_dbus_adr = 32'h3000; i_dbus_cyc = 1'b1;
        step();
        step();
        i_rst = 1'b1;
        step();
        check("t4_rst_cyc", 32'(o_wb_cyc), 32'd0);
        check("t4_rst_adr", o_wb_adr, 32'd0);
        i_rst = 1'b0; i_dbus_cyc = 1'b0; i_wb_ack = 1'b1;
        step();
        check("t4_late_ack", 32'(o_dbus_ack), 32'd0);
        i_wb_ack = 1'b0; i_ibus_adr = 32'h4000; i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
        step();
        check("t4_ibus_first", o_wb_adr, 32'h4000);
        i_wb_ack = 1'b1;
        step();
        i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
        step();
        step();

        // Hung slave
        reset_dut();
        i_ibus_adr = 32'h500; i_ibus_cyc = 1'b1;
        step();
`ifdef SERV_WB_ARBITER_TIMEOUT_EN
        idx = 0; n_to = 0;
        repeat (20) begin
            step();
            idx++;
            n_to += int'(o_timeout);
            if (o_ibus_ack) begin
                check("to_latency", 32'(idx), 32'(TO_CYCLES));
                check("to_rdt", o_ibus_rdt, 32'hFFFF_FFFF);
                i_ibus_cyc = 1'b0;
            end
        end
        check("to_pulses", 32'(n_to), 32'd1);
`else
        idx = 0; n_to = 0;
        repeat (1000) step();
        check("no_to_cyc", 32'(o_wb_cyc), 32'd1);
        i_ibus_cyc = 1'b0;
        step();
        step();
`endif

        // dbus abort, pending ibus granted two edges later
        reset_dut();
        i_dbus_adr = 32'h7000; i_dbus_cyc = 1'b1;
        step();
        i_ibus_adr = 32'h600; i_ibus_cyc = 1'b1;
        step();
        i_dbus_cyc = 1'b0;
        step();
        check("t6_cyc_fall", 32'(o_wb_cyc), 32'd0);
        check("t6_no_dack", 32'(o_dbus_ack), 32'd0);
        step();
        check("t6_regrant", 32'(o_wb_cyc), 32'd1);
        check("t6_ibus_adr", o_wb_adr, 32'h600);
        i_wb_ack = 1'b1;
        step();
        i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
        step();

        // Random masters, slave and occasional reset
        reset_dut();
        repeat (3000) begin
            step();
            if (o_ibus_ack) i_ibus_cyc = 1'b0;
            else if (i_ibus_cyc) begin
                if ($urandom_range(0, 49) == 0) i_ibus_cyc = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_ibus_cyc = 1'b1;
                i_ibus_adr = $urandom;
            end
            if (o_dbus_ack) i_dbus_cyc = 1'b0;
            else if (i_dbus_cyc) begin
                if ($urandom_range(0, 49) == 0) i_dbus_cyc = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_dbus_cyc = 1'b1;
                i_dbus_adr = $urandom;
                i_dbus_dat = $urandom;
                i_dbus_sel = 4'($urandom);
                i_dbus_we  = 1'($urandom);
            end
            i_wb_ack = o_wb_cyc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            i_wb_rdt = $urandom;
            i_rst    = ($urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
